// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_JALRLINK = 4'd11,
        S_BRANCH   = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_ILLEGAL  = 4'd15
    } state_t;

    // Instruction class seen by the ALU decoder.
    localparam logic [1:0] OPC_OTHER = 2'd0;
    localparam logic [1:0] OPC_R     = 2'd1;
    localparam logic [1:0] OPC_I     = 2'd2;
    localparam logic [1:0] OPC_B     = 2'd3;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] RS_ALUOUT = 2'b00;
    localparam logic [1:0] RS_RDATA  = 2'b01;
    localparam logic [1:0] RS_ALURES = 2'b10;

    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_OLDPC = 2'b01;
    localparam logic [1:0] SA_RS1   = 2'b10;
    localparam logic [1:0] SA_ZERO  = 2'b11;

    localparam logic [1:0] SB_RS2  = 2'b00;
    localparam logic [1:0] SB_IMM  = 2'b01;
    localparam logic [1:0] SB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/aludecoder_ext.sv
// Combinational funct3/funct7 decode to an ALU operation, plus detection of
// funct encodings that are not valid RV32I for the given instruction class.
module aludecoder_ext
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] i_class,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [3:0] o_alucontrol,
    output logic       o_bad_funct
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_funct3)
            // Only register-register ops can subtract; addi ignores imm[10].
            3'b000: o_alucontrol = (i_class == OPC_R && i_funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: o_alucontrol = ALU_SLL;
            3'b010: o_alucontrol = ALU_SLT;
            3'b011: o_alucontrol = ALU_SLTU;
            3'b100: o_alucontrol = ALU_XOR;
            3'b101: o_alucontrol = i_funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: o_alucontrol = ALU_OR;
            default: o_alucontrol = ALU_AND;
        endcase
    end

    always_comb begin
        o_bad_funct = 1'b0;
        case (i_class)
            OPC_R: o_bad_funct = !((i_funct7 == 7'h00) ||
                                   (i_funct7 == 7'h20 && (i_funct3 == 3'b000 || i_funct3 == 3'b101)));
            OPC_I: begin
                if (i_funct3 == 3'b001)
                    o_bad_funct = (i_funct7 != 7'h00);
                else if (i_funct3 == 3'b101)
                    o_bad_funct = !(i_funct7 == 7'h00 || i_funct7 == 7'h20);
            end
            OPC_B: o_bad_funct = (i_funct3 == 3'b010 || i_funct3 == 3'b011);
            default: o_bad_funct = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controlunit.sv
// Multi-cycle RV32I control FSM sequencing a shared datapath and unified memory;
// memory states stall on mem_ready, write enables are held low during reset.
module multicycle_controlunit
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT      = 1'b1,
    parameter bit STRICT_DECODE = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] immsrc,
    output logic [3:0] alucontrol,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state_o
);

    state_t     r_state;
    state_t     w_next;
    logic       w_ready;
    logic       w_taken;
    logic       w_bad_funct;
    logic       w_strict_bad;
    logic [1:0] w_class;
    logic [3:0] w_alu_dec;
    logic       w_pcwrite, w_memread, w_memwrite, w_irwrite, w_regwrite;

    assign w_ready = MEM_WAIT ? mem_ready : 1'b1;

    always_comb begin
        case (op)
            OP_RTYPE:  w_class = OPC_R;
            OP_ITYPE:  w_class = OPC_I;
            OP_BRANCH: w_class = OPC_B;
            default:   w_class = OPC_OTHER;
        endcase
    end

    aludecoder_ext u_aludec (
        .i_class      (w_class),
        .i_funct3     (funct3),
        .i_funct7     (funct7),
        .o_alucontrol (w_alu_dec),
        .o_bad_funct  (w_bad_funct)
    );

    assign w_strict_bad = STRICT_DECODE && w_bad_funct;

    // Flags come from the rs1-rs2 subtract performed in BRANCH itself.
    always_comb begin
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = lt;
            3'b101:  w_taken = !lt;
            3'b110:  w_taken = ltu;
            3'b111:  w_taken = !ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (w_strict_bad)
                    w_next = S_ILLEGAL;
                else begin
                    case (op)
                        OP_LOAD, OP_STORE: w_next = S_MEMADR;
                        OP_RTYPE:          w_next = S_EXECR;
                        OP_ITYPE:          w_next = S_EXECI;
                        OP_JAL:            w_next = S_JAL;
                        OP_JALR:           w_next = S_JALR;
                        OP_BRANCH:         w_next = S_BRANCH;
                        OP_LUI:            w_next = S_LUI;
                        OP_AUIPC:          w_next = S_AUIPC;
                        default:           w_next = S_ILLEGAL;
                    endcase
                end
            end
            S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (w_ready) w_next = S_MEMWB;
            S_MEMWRITE: if (w_ready) w_next = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC: w_next = S_ALUWB;
            S_JALR:     w_next = S_JALRLINK;
            default:    w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_pcwrite  = 1'b0;
        adrsrc     = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        resultsrc  = RS_ALUOUT;
        alusrca    = SA_PC;
        alusrcb    = SB_RS2;
        immsrc     = IMM_I;
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_memread = 1'b1;
                alusrcb   = SB_FOUR;
                resultsrc = RS_ALURES;
                w_pcwrite = w_ready;
                w_irwrite = w_ready;
            end
            S_DECODE: begin
                // Precompute the branch/jump target into ALUOut.
                alusrca = SA_OLDPC;
                alusrcb = SB_IMM;
                immsrc  = (op == OP_BRANCH) ? IMM_B : IMM_J;
            end
            S_MEMADR: begin
                alusrca = SA_RS1;
                alusrcb = SB_IMM;
                immsrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                adrsrc    = 1'b1;
                w_memread = 1'b1;
            end
            S_MEMWB: begin
                resultsrc  = RS_RDATA;
                w_regwrite = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                w_memwrite = 1'b1;
                instr_done = w_ready;
            end
            S_EXECR: begin
                alusrca    = SA_RS1;
                alusrcb    = SB_RS2;
                alucontrol = w_alu_dec;
            end
            S_EXECI: begin
                alusrca    = SA_RS1;
                alusrcb    = SB_IMM;
                alucontrol = w_alu_dec;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alusrca   = SA_OLDPC;
                alusrcb   = SB_FOUR;
                w_pcwrite = 1'b1;
            end
            S_JALR: begin
                alusrca   = SA_RS1;
                alusrcb   = SB_IMM;
                resultsrc = RS_ALURES;
                w_pcwrite = 1'b1;
            end
            S_JALRLINK: begin
                // rs1 was consumed last cycle, so rd==rs1 is safe to overwrite.
                alusrca    = SA_OLDPC;
                alusrcb    = SB_FOUR;
                resultsrc  = RS_ALURES;
                w_regwrite = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = SA_RS1;
                alusrcb    = SB_RS2;
                alucontrol = ALU_SUB;
                w_pcwrite  = w_taken;
                instr_done = 1'b1;
            end
            S_LUI: begin
                alusrca = SA_ZERO;
                alusrcb = SB_IMM;
                immsrc  = IMM_U;
            end
            S_AUIPC: begin
                alusrca = SA_OLDPC;
                alusrcb = SB_IMM;
                immsrc  = IMM_U;
            end
            default: begin
                illegal    = 1'b1;
                instr_done = 1'b1;
            end
        endcase
    end

    assign pcwrite  = w_pcwrite  & reset_n;
    assign memread  = w_memread  & reset_n;
    assign memwrite = w_memwrite & reset_n;
    assign irwrite  = w_irwrite  & reset_n;
    assign regwrite = w_regwrite & reset_n;
    assign state_o  = r_state;

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Randomized self-checking bench for multicycle_controlunit against an
// instruction-level reference model (expected state path and control word per cycle).
module tb_multicycle_controlunit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero, lt, ltu;
    logic       mem_ready;
    logic       pcwrite, adrsrc, memread, memwrite, irwrite, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb;
    logic [2:0] immsrc;
    logic [3:0] alucontrol;
    logic       illegal, instr_done;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYP = 7'b0110011,
                           ITYP = 7'b0010011, JAL = 7'b1101111, JALR = 7'b1100111,
                           BRAN = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111;

    always #5 clk = ~clk;

    multicycle_controlunit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .memread    (memread),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immsrc     (immsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .instr_done (instr_done),
        .state_o    (state_o)
    );

    logic [20:0] obs;
    assign obs = {pcwrite, adrsrc, memread, memwrite, irwrite, regwrite, resultsrc,
                  alusrca, alusrcb, immsrc, alucontrol, illegal, instr_done};

    function automatic bit is_legal(logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
        case (o)
            RTYP: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            ITYP: begin
                if (f3 == 3'd1) return f7 == 7'h00;
                if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
                return 1'b1;
            end
            BRAN: return !(f3 == 3'd2 || f3 == 3'd3);
            LOAD, STORE, JAL, JALR, LUI, AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Mnemonic-level ALU op: add/sub/sll/slt/sltu/xor/srl/sra/or/and.
    function automatic logic [3:0] ref_alu(logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        if (f3 == 3'd0 && o == RTYP && f7[5]) return 4'd1;
        if (f3 == 3'd5 && f7[5]) return 4'd9;
        return tbl[f3];
    endfunction

    function automatic bit ref_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [20:0] ref_ctrl(int st, bit rdy, bit tk, logic [3:0] alu, logic [6:0] o);
        logic pcw = 0, adr = 0, mr = 0, mw = 0, irw = 0, rw = 0, ill = 0, dn = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0;
        logic [2:0] im = 0;
        logic [3:0] al = 0;
        case (st)
            0:  begin mr = 1; sb = 2; rs = 2; pcw = rdy; irw = rdy; end
            1:  begin sa = 1; sb = 1; im = (o == BRAN) ? 3'd2 : 3'd3; end
            2:  begin sa = 2; sb = 1; im = (o == STORE) ? 3'd1 : 3'd0; end
            3:  begin adr = 1; mr = 1; end
            4:  begin rs = 1; rw = 1; dn = 1; end
            5:  begin adr = 1; mw = 1; dn = rdy; end
            6:  begin sa = 2; sb = 0; al = alu; end
            7:  begin sa = 2; sb = 1; al = alu; end
            8:  begin rw = 1; dn = 1; end
            9:  begin sa = 1; sb = 2; pcw = 1; end
            10: begin sa = 2; sb = 1; rs = 2; pcw = 1; end
            11: begin sa = 1; sb = 2; rs = 2; rw = 1; dn = 1; end
            12: begin sa = 2; sb = 0; al = 4'd1; pcw = tk; dn = 1; end
            13: begin sa = 3; sb = 1; im = 3'd4; end
            14: begin sa = 1; sb = 1; im = 3'd4; end
            default: begin ill = 1; dn = 1; end
        endcase
        return {pcw, adr, mr, mw, irw, rw, rs, sa, sb, im, al, ill, dn};
    endfunction

    // Runs one instruction from FETCH, checking state and control word every cycle.
    task automatic run_instr(string name, logic [6:0] o, logic [2:0] f3, logic [6:0] f7,
                             int fwait, int mwait, logic [31:0] a, logic [31:0] b);
        logic [3:0] st_q[$];
        bit         rdy_q[$];
        bit         tk  = ref_taken(f3, a, b);
        logic [3:0] alu = ref_alu(o, f3, f7);
        logic [20:0] exp_ctrl;
        repeat (fwait) begin st_q.push_back(4'd0); rdy_q.push_back(1'b0); end
        st_q.push_back(4'd0); rdy_q.push_back(1'b1);
        st_q.push_back(4'd1); rdy_q.push_back(1'($urandom));
        if (!is_legal(o, f3, f7)) begin
            st_q.push_back(4'd15); rdy_q.push_back(1'($urandom));
        end else begin
            case (o)
                LOAD: begin
                    st_q.push_back(4'd2); rdy_q.push_back(1'($urandom));
                    repeat (mwait) begin st_q.push_back(4'd3); rdy_q.push_back(1'b0); end
                    st_q.push_back(4'd3); rdy_q.push_back(1'b1);
                    st_q.push_back(4'd4); rdy_q.push_back(1'($urandom));
                end
                STORE: begin
                    st_q.push_back(4'd2); rdy_q.push_back(1'($urandom));
                    repeat (mwait) begin st_q.push_back(4'd5); rdy_q.push_back(1'b0); end
                    st_q.push_back(4'd5); rdy_q.push_back(1'b1);
                end
                RTYP:  begin st_q.push_back(4'd6);  st_q.push_back(4'd8);  end
                ITYP:  begin st_q.push_back(4'd7);  st_q.push_back(4'd8);  end
                JAL:   begin st_q.push_back(4'd9);  st_q.push_back(4'd8);  end
                JALR:  begin st_q.push_back(4'd10); st_q.push_back(4'd11); end
                LUI:   begin st_q.push_back(4'd13); st_q.push_back(4'd8);  end
                AUIPC: begin st_q.push_back(4'd14); st_q.push_back(4'd8);  end
                default: st_q.push_back(4'd12);
            endcase
            while (rdy_q.size() < st_q.size()) rdy_q.push_back(1'($urandom));
        end
        zero = (a == b);
        lt   = $signed(a) < $signed(b);
        ltu  = a < b;
        for (int i = 0; i < st_q.size(); i++) begin
            mem_ready = rdy_q[i];
            if (st_q[i] == 4'd0) {op, funct3, funct7} = 17'($urandom);
            else begin op = o; funct3 = f3; funct7 = f7; end
            #2;
            exp_ctrl = ref_ctrl(int'(st_q[i]), rdy_q[i], tk, alu, o);
            n_checks++;
            if (state_o !== st_q[i]) begin
                n_errors++;
                $display("FAIL %s step %0d state: got %0d expected %0d", name, i, state_o, st_q[i]);
            end
            n_checks++;
            if (obs !== exp_ctrl) begin
                n_errors++;
                $display("FAIL %s step %0d ctrl: got %h expected %h (state %0d)",
                         name, i, obs, exp_ctrl, st_q[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; mem_ready = 1'b1; op = RTYP; funct3 = 0; funct7 = 0;
        zero = 0; lt = 0; ltu = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (state_o !== 4'd0) begin
            n_errors++; $display("FAIL reset_state: got %0d expected 0", state_o);
        end
        n_checks++;
        if ({pcwrite, irwrite, regwrite, memwrite, memread} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_enables: got %b expected 00000",
                     {pcwrite, irwrite, regwrite, memwrite, memread});
        end
        @(negedge clk);
        reset_n = 1'b1; mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 4'd0 || memread !== 1'b1 || pcwrite !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: state %0d memread %b pcwrite %b expected 0 1 0",
                     state_o, memread, pcwrite);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight;
        op = LOAD; funct3 = 3'd2; funct7 = 7'd0;
        mem_ready = 1'b1; @(posedge clk); #1;
        mem_ready = 1'b0; @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (state_o !== 4'd3 || memread !== 1'b1) begin
            n_errors++;
            $display("FAIL midflight_memread: state %0d memread %b expected 3 1", state_o, memread);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 4'd0 || {pcwrite, irwrite, regwrite, memwrite, memread} !== 5'b0) begin
            n_errors++;
            $display("FAIL midflight_reset: state %0d enables %b expected 0 00000",
                     state_o, {pcwrite, irwrite, regwrite, memwrite, memread});
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (state_o !== 4'd0 || memread !== 1'b1) begin
            n_errors++;
            $display("FAIL midflight_release: state %0d memread %b expected 0 1", state_o, memread);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu_ops;
        run_instr("sub",  RTYP, 3'd0, 7'h20, 0, 0, 32'd5, 32'd3);
        run_instr("sra",  RTYP, 3'd5, 7'h20, 0, 0, 32'd5, 32'd3);
        run_instr("sltu", RTYP, 3'd3, 7'h00, 1, 0, 32'd5, 32'd3);
        run_instr("addi", ITYP, 3'd0, 7'h20, 0, 0, 32'd1, 32'd1);
        run_instr("srai", ITYP, 3'd5, 7'h20, 0, 0, 32'd1, 32'd1);
        run_instr("lui",  LUI,  3'd3, 7'h11, 0, 0, 32'd0, 32'd0);
        run_instr("auipc", AUIPC, 3'd6, 7'h7f, 2, 0, 32'd0, 32'd0);
    endtask

    task automatic test_memory;
        run_instr("lw_wait3", LOAD,  3'd2, 7'd0, 0, 3, 32'd0, 32'd0);
        run_instr("lw_nowait", LOAD, 3'd2, 7'd0, 0, 0, 32'd0, 32'd0);
        run_instr("sw_wait2", STORE, 3'd2, 7'd0, 1, 2, 32'd0, 32'd0);
    endtask

    task automatic test_branches;
        run_instr("bne_eq",   BRAN, 3'd1, 7'd0, 0, 0, 32'd7, 32'd7);
        run_instr("bne_ne",   BRAN, 3'd1, 7'd0, 0, 0, 32'd7, 32'd8);
        run_instr("bltu_lt",  BRAN, 3'd6, 7'd0, 0, 0, 32'd1, 32'd2);
        run_instr("bgeu_lt",  BRAN, 3'd7, 7'd0, 0, 0, 32'd1, 32'd2);
        run_instr("blt_neg",  BRAN, 3'd4, 7'd0, 0, 0, 32'hffffffff, 32'd1);
        run_instr("bltu_neg", BRAN, 3'd6, 7'd0, 0, 0, 32'hffffffff, 32'd1);
        run_instr("beq_eq",   BRAN, 3'd0, 7'd0, 0, 0, 32'd9, 32'd9);
        run_instr("bge_neg",  BRAN, 3'd5, 7'd0, 0, 0, 32'h80000000, 32'd0);
    endtask

    task automatic test_jumps;
        run_instr("jal",  JAL,  3'd5, 7'h33, 0, 0, 32'd0, 32'd0);
        run_instr("jalr", JALR, 3'd0, 7'h00, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic test_illegal;
        run_instr("op_zero",   7'd0, 3'd0, 7'd0,  0, 0, 32'd0, 32'd0);
        run_instr("srai_40",   ITYP, 3'd5, 7'h40, 0, 0, 32'd0, 32'd0);
        run_instr("sll_f7_20", RTYP, 3'd1, 7'h20, 0, 0, 32'd0, 32'd0);
        run_instr("r_f7_01",   RTYP, 3'd0, 7'h01, 0, 0, 32'd0, 32'd0);
        run_instr("b_f3_2",    BRAN, 3'd2, 7'd0,  0, 0, 32'd0, 32'd0);
    endtask

    task automatic test_random;
        logic [6:0] ops [10];
        logic [6:0] o, f7;
        logic [31:0] a, b;
        ops = '{LOAD, STORE, RTYP, ITYP, JAL, JALR, BRAN, LUI, AUIPC, 7'd0};
        for (int n = 0; n < 60; n++) begin
            o = ops[$urandom_range(0, 9)];
            if (o == 7'd0) o = 7'($urandom);
            case ($urandom_range(0, 3))
                0, 1: f7 = 7'h00;
                2:    f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr("random", o, 3'($urandom), f7, $urandom_range(0, 2),
                      $urandom_range(0, 3), a, b);
        end
    endtask

    initial begin
        test_reset;
        test_alu_ops;
        test_memory;
        test_branches;
        test_jumps;
        test_illegal;
        test_reset_midflight;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
